// File: rtl/mmm_pkg.sv
// Shared types and constants for the fetch-side instruction cache.
// Contents:
//   XLEN, OFFSET, ICACHE_OFFSET, ICACHE_LINE_LEN, ICACHE_IDX_BITS  - geometry constants
//   icache_out_t      - response record {pc, line}
//   icache_state_t    - miss-handling FSM states
//   icache_mem_req_t  - refill request record {valid, addr}
package mmm_pkg;

  localparam int XLEN            = 16;
  localparam int OFFSET          = 1;
  localparam int ICACHE_OFFSET   = 1;
  localparam int ICACHE_LINE_LEN = 32;
  localparam int ICACHE_IDX_BITS = 2;

  typedef struct packed {
    logic [XLEN-1:0]            pc;
    logic [ICACHE_LINE_LEN-1:0] line;
  } icache_out_t;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} icache_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
  } icache_mem_req_t;

endpackage

// File: rtl/icache_dm_array.sv
// Storage for the direct-mapped instruction cache: per-line valid bits,
// tag array and data array.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (valid bits only)
//   clr_i          clear all valid bits at the next edge (wins over a write)
//   rd_idx_i       combinational read index
//   rd_valid_o     valid bit of the indexed line
//   rd_tag_o       tag of the indexed line
//   rd_line_o      data of the indexed line
//   we_i           write enable: install tag/data and set valid at wr_idx_i
//   wr_idx_i       write index
//   wr_tag_i       tag to install
//   wr_line_i      line data to install
module icache_dm_array
  import mmm_pkg::*;
#(
  parameter int IDX_BITS = ICACHE_IDX_BITS,
  parameter int TAG_LEN  = 12,
  parameter int LINE_LEN = ICACHE_LINE_LEN
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_valid_o,
  output logic [TAG_LEN-1:0]  rd_tag_o,
  output logic [LINE_LEN-1:0] rd_line_o,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [TAG_LEN-1:0]  wr_tag_i,
  input  logic [LINE_LEN-1:0] wr_line_i
);

  localparam int NLINES = 1 << IDX_BITS;

  logic [NLINES-1:0]   valid_q, valid_d;
  logic [TAG_LEN-1:0]  tag_q  [NLINES];
  logic [LINE_LEN-1:0] data_q [NLINES];

  // A clear in the same cycle as a refill write leaves the line invalid.
  always_comb begin
    valid_d = valid_q;
    if (clr_i) begin
      valid_d = '0;
    end else if (we_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data contents are never reset; the valid bit guards them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, responder side of the fetch interface.
// Hits answer one cycle after accept; misses fetch a whole line from memory,
// install it and then answer. Only one miss is outstanding at a time.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   flush_i            invalidate all lines and kill any in-flight miss
//   req_valid_i/req_ready_o/req_pc_i        fetch request
//   resp_valid_o/resp_ready_i/resp_o        response {pc, line}
//   mem_req_valid_o/mem_req_ready_i/mem_req_addr_o  refill request (line aligned)
//   mem_resp_valid_i/mem_resp_line_i        refill data (single beat)
module icache_dm
  import mmm_pkg::*;
#(
  parameter int IDX_BITS = ICACHE_IDX_BITS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [XLEN-1:0]            req_pc_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output icache_out_t                resp_o,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [XLEN-1:0]            mem_req_addr_o,
  input  logic                       mem_resp_valid_i,
  input  logic [ICACHE_LINE_LEN-1:0] mem_resp_line_i
);

  localparam int LOFF    = ICACHE_OFFSET + OFFSET;
  localparam int TAG_LEN = XLEN - LOFF - IDX_BITS;

  icache_state_t   state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            resp_valid_q, resp_valid_d;
  icache_out_t     resp_q, resp_d;
  icache_mem_req_t mem_req;

  logic [IDX_BITS-1:0]        req_idx, pc_idx;
  logic [TAG_LEN-1:0]         req_tag, pc_tag;
  logic                       rd_valid;
  logic [TAG_LEN-1:0]         rd_tag;
  logic [ICACHE_LINE_LEN-1:0] rd_line;
  logic                       accept, hit, refill, install;

  assign req_idx = req_pc_i[LOFF+IDX_BITS-1:LOFF];
  assign req_tag = req_pc_i[XLEN-1:LOFF+IDX_BITS];
  assign pc_idx  = pc_q[LOFF+IDX_BITS-1:LOFF];
  assign pc_tag  = pc_q[XLEN-1:LOFF+IDX_BITS];

  assign accept  = req_valid_i & req_ready_o;
  assign hit     = rd_valid & (rd_tag == req_tag);
  assign refill  = (state_q == MISS_WAIT) & mem_resp_valid_i;
  // A killed refill still completes the memory handshake but is dropped.
  assign install = refill & ~kill_q;

  icache_dm_array #(
    .IDX_BITS (IDX_BITS),
    .TAG_LEN  (TAG_LEN),
    .LINE_LEN (ICACHE_LINE_LEN)
  ) u_array (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (flush_i),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .we_i       (install),
    .wr_idx_i   (pc_idx),
    .wr_tag_i   (pc_tag),
    .wr_line_i  (mem_resp_line_i)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a flush never aborts MISS_REQ since the valid must stay up
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && !hit)   state_d = MISS_REQ;
      MISS_REQ:  if (mem_req_ready_i)  state_d = MISS_WAIT;
      MISS_WAIT: if (mem_resp_valid_i) state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready_o = 1'b0;
    mem_req     = '0;
    case (state_q)
      IDLE:     req_ready_o = ~flush_i & (~resp_valid_q | resp_ready_i);
      MISS_REQ: begin
        mem_req.valid = 1'b1;
        mem_req.addr  = {pc_q[XLEN-1:LOFF], {LOFF{1'b0}}};
      end
      default: ;
    endcase
  end

  assign mem_req_valid_o = mem_req.valid;
  assign mem_req_addr_o  = mem_req.addr;

  // Request PC, kill flag and response register next state
  always_comb begin
    pc_d = accept ? req_pc_i : pc_q;

    kill_d = kill_q;
    if (refill) begin
      kill_d = 1'b0;
    end else if (flush_i && (state_q != IDLE)) begin
      kill_d = 1'b1;
    end

    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    if (flush_i) begin
      resp_valid_d = 1'b0;
    end else if (accept && hit) begin
      resp_valid_d = 1'b1;
      resp_d.pc    = req_pc_i;
      resp_d.line  = rd_line;
    end else if (install) begin
      resp_valid_d = 1'b1;
      resp_d.pc    = pc_q;
      resp_d.line  = mem_resp_line_i;
    end else if (resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kill_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      kill_q       <= kill_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pc_q <= pc_d;
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_o       = resp_q;

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed sequences for miss, hit,
// backpressure, memory stall and kill; a table of access vectors; and a
// randomized phase checked against a behavioural cache model.
module tb_icache_dm;
  import mmm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [15:0] req_pc_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  icache_out_t resp_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [15:0] mem_req_addr_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_line_i;

  int checks = 0;
  int errors = 0;

  icache_dm dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_pc_i         (req_pc_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_o           (resp_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_line_i  (mem_resp_line_i)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] pc;
    logic        miss;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl[10];

  // Memory contents: deterministic function of the line address.
  function automatic logic [31:0] memdata(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk48(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic send_req(input logic [15:0] pc);
    int n = 0;
    req_valid_i = 1'b1;
    req_pc_i    = pc;
    #1;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: got req_ready_o=0 expected 1 for pc %h", pc);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  // Serve one refill: hold ready low for 'stall' cycles, answer 'delay' cycles later.
  task automatic serve_mem(input logic [15:0] exp_addr, input logic [31:0] line,
                           input int stall, input int delay);
    int n = 0;
    while (!mem_req_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("mem_req_valid", mem_req_valid_o, 1'b1);
    chk16("mem_req_addr", mem_req_addr_o, exp_addr);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk1("mem_req_valid_held", mem_req_valid_o, 1'b1);
      chk16("mem_req_addr_held", mem_req_addr_o, exp_addr);
    end
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < delay; i++) @(negedge clk);
    mem_resp_valid_i = 1'b1;
    mem_resp_line_i  = line;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    mem_resp_line_i  = $urandom;
  endtask

  task automatic access(input logic [15:0] pc, input logic exp_miss, input logic [15:0] addr,
                        input logic [31:0] line, input int stall, input int delay);
    send_req(pc);
    chk1("miss", mem_req_valid_o, exp_miss);
    if (mem_req_valid_o) serve_mem(addr, line, stall, delay);
    chk1("resp_valid", resp_valid_o, 1'b1);
    chk48("resp", resp_o, {pc, line});
  endtask

  bit          mvalid[4];
  int          mtag[4];

  initial begin
    tbl[0] = '{16'h0054, 1'b1, 16'h0054};
    tbl[1] = '{16'h0014, 1'b1, 16'h0014};
    tbl[2] = '{16'h0017, 1'b0, 16'h0014};
    tbl[3] = '{16'h0020, 1'b1, 16'h0020};
    tbl[4] = '{16'h0023, 1'b0, 16'h0020};
    tbl[5] = '{16'h0056, 1'b1, 16'h0054};
    tbl[6] = '{16'h0014, 1'b1, 16'h0014};
    tbl[7] = '{16'h0024, 1'b1, 16'h0024};
    tbl[8] = '{16'h0021, 1'b0, 16'h0020};
    tbl[9] = '{16'h0026, 1'b0, 16'h0024};

    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_pc_i = '0;
    resp_ready_i = 1'b1; mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
    mem_resp_line_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk1("reset_resp_valid", resp_valid_o, 1'b0);
    chk48("reset_resp", resp_o, 48'h0);
    chk1("reset_mem_req_valid", mem_req_valid_o, 1'b0);
    chk16("reset_mem_req_addr", mem_req_addr_o, 16'h0);
    chk1("reset_req_ready", req_ready_o, 1'b1);

    // Stray memory response in IDLE is ignored.
    @(negedge clk);
    mem_resp_valid_i = 1'b1;
    mem_resp_line_i  = 32'h12345678;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    chk1("stray_resp_ignored", resp_valid_o, 1'b0);

    // Cold miss with memory stall of 4 cycles, data 3 cycles after the handshake.
    send_req(16'h0016);
    chk1("cold_miss", mem_req_valid_o, 1'b1);
    chk1("cold_no_resp", resp_valid_o, 1'b0);
    serve_mem(16'h0014, 32'hDEADBEEF, 4, 3);
    chk1("cold_resp_valid", resp_valid_o, 1'b1);
    chk48("cold_resp", resp_o, {16'h0016, 32'hDEADBEEF});
    @(negedge clk);

    // Hit with 5 cycles of response backpressure.
    resp_ready_i = 1'b0;
    send_req(16'h0015);
    chk1("hit_no_mem_req", mem_req_valid_o, 1'b0);
    chk1("hit_resp_valid", resp_valid_o, 1'b1);
    chk48("hit_resp", resp_o, {16'h0015, 32'hDEADBEEF});
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1;
      req_pc_i    = 16'h0054;
      #1;
      chk1("bp_req_ready", req_ready_o, 1'b0);
      @(negedge clk);
      chk1("bp_resp_valid", resp_valid_o, 1'b1);
      chk48("bp_resp_stable", resp_o, {16'h0015, 32'hDEADBEEF});
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    #1;
    chk1("bp_release_ready", req_ready_o, 1'b1);
    @(negedge clk);
    chk1("bp_resp_drop", resp_valid_o, 1'b0);

    // Table of accesses: conflicts, hits and replacements.
    for (int i = 0; i < 10; i++) begin
      access(tbl[i].pc, tbl[i].miss, tbl[i].addr, memdata(tbl[i].addr), i % 3, i % 2);
    end
    @(negedge clk);

    // Kill in MISS_WAIT: refill is dropped, next request misses again.
    send_req(16'h0016);
    chk1("kill_miss", mem_req_valid_o, 1'b1);
    chk16("kill_addr", mem_req_addr_o, 16'h0014);
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk1("kill_resp_valid_after_flush", resp_valid_o, 1'b0);
    mem_resp_valid_i = 1'b1;
    mem_resp_line_i  = 32'hBADBAD00;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("kill_no_resp", resp_valid_o, 1'b0);
      @(negedge clk);
    end
    access(16'h0016, 1'b1, 16'h0014, memdata(16'h0014), 0, 1);
    @(negedge clk);

    // Flush while the refill request is still stalled in MISS_REQ.
    send_req(16'h0020);
    chk1("kill2_miss", mem_req_valid_o, 1'b1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk1("kill2_req_held", mem_req_valid_o, 1'b1);
    chk16("kill2_addr_held", mem_req_addr_o, 16'h0020);
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b1;
    mem_resp_line_i  = 32'h0BAD0BAD;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    chk1("kill2_no_resp", resp_valid_o, 1'b0);
    access(16'h0021, 1'b1, 16'h0020, memdata(16'h0020), 1, 0);
    access(16'h0016, 1'b1, 16'h0014, memdata(16'h0014), 0, 0);
    @(negedge clk);

    // Randomized accesses against a behavioural cache model.
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk1("rand_flush_resp", resp_valid_o, 1'b0);
    for (int k = 0; k < 4; k++) mvalid[k] = 1'b0;
    for (int n = 0; n < 150; n++) begin
      logic [15:0] pc;
      int          idx, tag;
      logic        miss;
      if ($urandom_range(0, 9) == 0) begin
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk1("rand_flush_resp", resp_valid_o, 1'b0);
        for (int k = 0; k < 4; k++) mvalid[k] = 1'b0;
      end
      pc   = 16'($urandom_range(0, 63));
      idx  = (int'(pc) / 4) % 4;
      tag  = int'(pc) / 16;
      miss = !(mvalid[idx] && mtag[idx] == tag);
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
      access(pc, miss, pc & 16'hFFFC, memdata(pc & 16'hFFFC),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
